// File: rtl/div_32_seq_pkg.sv
// div_pkg: shared types and constants for the sequential signed divider.
//   state_t     : divider FSM states
//   DIV_WIDTH   : default operand width
//   DIV_LATENCY : cycles from accepted start through the done cycle
package div_pkg;

  localparam int unsigned DIV_WIDTH   = 32;
  localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_32_seq_if.sv
// div_32_seq_if: request/response bundle for div_32_seq.
//   start    : request, sampled only while the divider is idle
//   rA, rB   : dividend / divisor, two's complement
//   busy     : operation in progress
//   done     : one-cycle completion pulse
//   rZ       : {remainder, quotient}
//   div_zero : divisor-zero flag (only when DIV_ZERO_DETECT_EN is defined)
// modports: master drives requests, slave is the divider.
interface div_32_seq_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   rA;
  logic [WIDTH-1:0]   rB;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] rZ;
`ifdef DIV_ZERO_DETECT_EN
  logic               div_zero;
`endif

  modport master (
    output start, rA, rB,
`ifdef DIV_ZERO_DETECT_EN
    input  div_zero,
`endif
    input  busy, done, rZ
  );

  modport slave (
    input  start, rA, rB,
`ifdef DIV_ZERO_DETECT_EN
    output div_zero,
`endif
    output busy, done, rZ
  );

endinterface

// File: rtl/div_32_seq_step.sv
// div_step: one combinational restoring-division iteration.
//   i_rem : partial remainder (always < i_div when i_div != 0)
//   i_quo : shifting dividend / quotient register
//   i_div : divisor magnitude
//   o_rem : next partial remainder
//   o_quo : next quotient register (new bit in the LSB)
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    // When the trial subtract succeeds the result is below i_div, so the
    // low WIDTH bits of the difference are exact.
    w_diff  = w_shift[WIDTH-1:0] - i_div;
    if (w_shift >= {1'b0, i_div}) begin
      o_rem = w_diff;
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_32_seq.sv
// div_32_seq: sequential signed divider, radix-2 restoring, one quotient bit
// per clock. Result rZ = {remainder, quotient}; quotient truncates toward
// zero and the remainder takes the sign of the dividend.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : div_32_seq_if slave (start, rA, rB, busy, done, rZ[, div_zero])
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor skips CALC, returns
// {rA, all ones} and raises div_zero.
module div_32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic         clock,
  input  logic         clear,
  div_32_seq_if.slave  bus
);

  localparam int unsigned DIV_ITER = WIDTH;
  localparam int unsigned CW       = $clog2(DIV_ITER + 1);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_rem, r_quo, r_div;
  logic               r_neg_rem, r_neg_quo;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic [2*WIDTH-1:0] r_rz;
`ifdef DIV_ZERO_DETECT_EN
  logic               r_dz_op;
  logic               r_div_zero;
`endif

  logic               w_busy;
  logic               w_start_ok;
  logic               w_skip_calc;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
  logic [WIDTH-1:0]   w_rem_fix, w_quo_fix;

  // The FSM is back in IDLE during the done cycle; r_done keeps a start in
  // that cycle from being accepted.
  assign w_start_ok = (r_state == IDLE) && bus.start && !r_done;
  assign w_last     = (r_cnt == CW'(DIV_ITER - 1));

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign w_a_mag = bus.rA[WIDTH-1] ? -bus.rA : bus.rA;
  assign w_b_mag = bus.rB[WIDTH-1] ? -bus.rB : bus.rB;

`ifdef DIV_ZERO_DETECT_EN
  assign w_skip_calc = (bus.rB == '0);
`else
  assign w_skip_calc = 1'b0;
`endif

  assign w_quo_fix = r_neg_quo ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_rem ? -r_rem : r_rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    unique case (r_state)
      IDLE: if (w_start_ok) w_state_nxt = w_skip_calc ? FIX : CALC;
      CALC: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = FIX;
      end
      FIX: begin
        w_busy      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_neg_rem  <= 1'b0;
      r_neg_quo  <= 1'b0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_rz       <= '0;
`ifdef DIV_ZERO_DETECT_EN
      r_dz_op    <= 1'b0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: if (w_start_ok) begin
          r_cnt     <= '0;
          r_div     <= w_b_mag;
          r_neg_rem <= bus.rA[WIDTH-1];
`ifdef DIV_ZERO_DETECT_EN
          r_dz_op    <= w_skip_calc;
          r_div_zero <= 1'b0;
`endif
          // Zero-divisor bypass preloads the final magnitudes so the common
          // sign-fix path yields {rA, all ones}.
          if (w_skip_calc) begin
            r_rem     <= w_a_mag;
            r_quo     <= '1;
            r_neg_quo <= 1'b0;
          end else begin
            r_rem     <= '0;
            r_quo     <= w_a_mag;
            r_neg_quo <= bus.rA[WIDTH-1] ^ bus.rB[WIDTH-1];
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_rz   <= {w_rem_fix, w_quo_fix};
          r_done <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          r_div_zero <= r_dz_op;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.rZ   = r_rz;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.div_zero = r_div_zero;
`endif

endmodule

// File: tb/tb_div_32_seq.sv
module tb_div_32_seq;
  import div_pkg::*;

  typedef struct {
    string       name;
    logic [63:0] rz;
    int          start_cyc;
    int          lat;
    logic        dz;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  div_32_seq_if #(.WIDTH(32)) bus();

  div_32_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  exp_t q[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endfunction

  // Scoreboard monitor: every done pulse pops one expected result.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        check("busy_with_done", 64'(bus.busy), 64'(0));
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1 required no pending operation");
        end else begin
          exp_t e;
          e = q.pop_front();
          check({e.name, "/rZ"}, bus.rZ, e.rz);
          check({e.name, "/latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
`ifdef DIV_ZERO_DETECT_EN
          check({e.name, "/div_zero"}, 64'(bus.div_zero), 64'(e.dz));
`endif
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.rA    = a;
    bus.rB    = b;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic launch(input string name, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] rz);
    exp_t e;
    @(negedge clock);
    issue(a, b);
    e.name      = name;
    e.rz        = rz;
    e.start_cyc = cyc;
    e.lat       = DIV_LATENCY - 1;
    e.dz        = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'h0) begin
      e.lat = 1;
      e.dz  = 1'b1;
    end
    check({name, "/div_zero_cleared"}, 64'(bus.div_zero), 64'(0));
`endif
    q.push_back(e);
    check({name, "/busy_after_start"}, 64'(bus.busy), 64'(1));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    n_total++;
    if (q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s/timeout: got %0d pending required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic run(input string name, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] rz);
    launch(name, a, b, rz);
    wait_drain(name);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.rA    = '0;
    bus.rB    = '0;
    clear     = 1'b0;
    repeat (3) @(negedge clock);
    clear = 1'b1;
    repeat (5) @(negedge clock);
    check("reset/busy", 64'(bus.busy), 64'(0));
    check("reset/done", 64'(bus.done), 64'(0));
    check("reset/rZ",   bus.rZ,        64'h0);

    run("pos_100_7",    32'd100,      32'd7,        64'h00000002_0000000E);
    run("neg_m100_7",   32'hFFFFFF9C, 32'd7,        64'hFFFFFFFE_FFFFFFF2);
    run("neg_100_m7",   32'd100,      32'hFFFFFFF9, 64'h00000002_FFFFFFF2);
    run("overflow",     32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run("small_7_100",  32'd7,        32'd100,      64'h00000007_00000000);
    run("neg_m7_m2",    32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003);
    run("min_by_1",     32'h80000000, 32'd1,        64'h00000000_80000000);
    run("m1_by_1",      32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF);

    // Start pulse while busy must not disturb the running operation.
    launch("busy_ignore", 32'd100, 32'd7, 64'h00000002_0000000E);
    repeat (9) @(negedge clock);
    bus.rA    = 32'd9;
    bus.rB    = 32'd3;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_ignore/busy", 64'(bus.busy), 64'(1));
    wait_drain("busy_ignore");

    // Start presented in the done cycle must be rejected.
    launch("done_cycle", 32'd20, 32'd4, 64'h00000000_00000005);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    bus.rA    = 32'd9;
    bus.rB    = 32'd3;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("done_cycle/start_rejected", 64'(bus.busy), 64'(0));
    wait_drain("done_cycle");
    repeat (3) @(negedge clock);
    check("done_cycle/rZ_hold", bus.rZ, 64'h00000000_00000005);

    // Asynchronous abort mid-CALC; no done may follow.
    @(negedge clock);
    issue(32'd100, 32'd7);
    repeat (19) @(negedge clock);
    clear = 1'b0;
    #1;
    check("abort/busy", 64'(bus.busy), 64'(0));
    check("abort/rZ",   bus.rZ,        64'h0);
    @(negedge clock);
    clear = 1'b1;
    repeat (40) @(negedge clock);
    run("after_abort", 32'd9, 32'd3, 64'h00000000_00000003);

    // Zero divisor: both builds give {55, all ones}; latency and flag differ.
    run("div_zero", 32'd55, 32'd0, 64'h00000037_FFFFFFFF);
`ifdef DIV_ZERO_DETECT_EN
    repeat (2) @(negedge clock);
    check("div_zero/held", 64'(bus.div_zero), 64'(1));
`endif
    run("after_zero", 32'd9, 32'd3, 64'h00000000_00000003);

    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
